// File: rtl/fetch_stage_ctrl.sv
// Purpose : owns the PC and the IF/ID register and applies hold/flush/redirect requests from the hazard unit.
//           It also keeps saturating stall/flush statistics, a stall watchdog and a sticky illegal-request flag.
// Latency : one cycle. Requests sampled on an edge are visible on the (registered) outputs right after it.
// Backpres: PCWrite=0 holds the PC; IF_ID_Write=0 holds IF/ID; IF_ID_flush loads a NOP and wins over IF_ID_Write.
//
// Ports
//   clk_i, rst_ni       rising-edge clock, asynchronous active-low reset
//   pc_write_i          1 = PC may advance/redirect, 0 = hold
//   if_id_write_i       1 = IF/ID captures the current fetch, 0 = hold
//   if_id_flush_i       1 = IF/ID becomes a NOP (overrides if_id_write_i)
//   redirect_valid_i    jump / jr / taken branch resolved in ID this cycle
//   redirect_pc_i       redirect target (low two bits ignored)
//   imem_rdata_i        instruction at imem_addr_o (combinational memory)
//   clr_stats_i         synchronous clear of counters and sticky flags
//   imem_addr_o         current PC
//   if_id_instr_o       IF/ID instruction
//   if_id_pc4_o         IF/ID PC+4
//   if_id_valid_o       IF/ID holds a real instruction
//   stall_cnt_o         saturating stall-cycle count
//   flush_cnt_o         saturating flush-cycle count
//   stall_timeout_o     sticky: a stall run reached WDOG_LIMIT cycles
//   protocol_err_o      sticky: IF/ID was written while the PC was held
module fetch_stage_ctrl #(
  parameter int                 ADDR_W     = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC   = '0,
  parameter int                 WDOG_LIMIT = 16,
  parameter int                 CNT_W      = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              pc_write_i,
  input  logic              if_id_write_i,
  input  logic              if_id_flush_i,
  input  logic              redirect_valid_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  input  logic [31:0]       imem_rdata_i,
  input  logic              clr_stats_i,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [31:0]       if_id_instr_o,
  output logic [ADDR_W-1:0] if_id_pc4_o,
  output logic              if_id_valid_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o,
  output logic              stall_timeout_o,
  output logic              protocol_err_o
);

  localparam int                RUN_W   = $clog2(WDOG_LIMIT + 1);
  localparam logic [RUN_W-1:0]  RUN_MAX = RUN_W'(WDOG_LIMIT);
  localparam logic [31:0]       NOP     = 32'h0000_0000;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] pc4_q, pc4_d;
  logic              valid_q, valid_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic              timeout_q, timeout_d;
  logic              perr_q, perr_d;

  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] redirect_aligned;
  logic              stall_cycle;
  logic              bad_request;

  // Adder wraps naturally modulo 2^ADDR_W.
  assign pc_plus4         = pc_q + ADDR_W'(4);
  // Masking (rather than slicing) keeps every redirect_pc_i bit in use.
  assign redirect_aligned = redirect_pc_i & ~ADDR_W'(3);
  assign stall_cycle      = !pc_write_i && !if_id_write_i && !if_id_flush_i;
  // Writing IF/ID while the PC is frozen re-captures the same instruction.
  assign bad_request      = (if_id_write_i && !pc_write_i) ||
                            (if_id_flush_i && !pc_write_i && if_id_write_i);

  // PC and IF/ID next state
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;

    // A redirect without PCWrite is dropped; the hazard unit re-presents it.
    if (pc_write_i) begin
      if (redirect_valid_i) pc_d = redirect_aligned;
      else                  pc_d = pc_plus4;
    end

    if (if_id_flush_i) begin
      instr_d = NOP;
      pc4_d   = '0;
      valid_d = 1'b0;
    end else if (if_id_write_i) begin
      instr_d = imem_rdata_i;
      pc4_d   = pc_plus4;
      valid_d = 1'b1;
    end
  end

  // Statistics, watchdog and error flag next state
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    run_d       = run_q;
    timeout_d   = timeout_q;
    perr_d      = perr_q;

    if (stall_cycle && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
    if (if_id_flush_i && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 1'b1;

    if (stall_cycle) begin
      if (run_q != RUN_MAX) run_d = run_q + 1'b1;
      if (run_d == RUN_MAX) timeout_d = 1'b1;
    end else begin
      run_d = '0;
    end

    if (bad_request) perr_d = 1'b1;

    // Clear has priority over any same-cycle increment or set.
    if (clr_stats_i) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
      run_d       = '0;
      timeout_d   = 1'b0;
      perr_d      = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q        <= RESET_PC;
      instr_q     <= NOP;
      pc4_q       <= '0;
      valid_q     <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      run_q       <= '0;
      timeout_q   <= 1'b0;
      perr_q      <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      pc4_q       <= pc4_d;
      valid_q     <= valid_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      run_q       <= run_d;
      timeout_q   <= timeout_d;
      perr_q      <= perr_d;
    end
  end

  assign imem_addr_o     = pc_q;
  assign if_id_instr_o   = instr_q;
  assign if_id_pc4_o     = pc4_q;
  assign if_id_valid_o   = valid_q;
  assign stall_cnt_o     = stall_cnt_q;
  assign flush_cnt_o     = flush_cnt_q;
  assign stall_timeout_o = timeout_q;
  assign protocol_err_o  = perr_q;

endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// Purpose : directed, table-driven check of fetch_stage_ctrl (RESET_PC=0x100, WDOG_LIMIT=4, CNT_W=4).
// Latency : each vector is driven after a rising edge and its expectation is compared 1ns after the next one.
// Backpres: not applicable; the bench drives every request directly.
module tb_fetch_stage_ctrl;

  localparam int CW = 4;

  logic          clk;
  logic          rst_n;
  logic          pcw, ifw, fl, rv, clr;
  logic [31:0]   rpc, rdata;
  logic [31:0]   addr, instr, pc4;
  logic          valid, tmo, perr;
  logic [CW-1:0] scnt, fcnt;

  int n_vec  = 0;
  int n_miss = 0;

  fetch_stage_ctrl #(
    .ADDR_W    (32),
    .RESET_PC  (32'h0000_0100),
    .WDOG_LIMIT(4),
    .CNT_W     (CW)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .pc_write_i      (pcw),
    .if_id_write_i   (ifw),
    .if_id_flush_i   (fl),
    .redirect_valid_i(rv),
    .redirect_pc_i   (rpc),
    .imem_rdata_i    (rdata),
    .clr_stats_i     (clr),
    .imem_addr_o     (addr),
    .if_id_instr_o   (instr),
    .if_id_pc4_o     (pc4),
    .if_id_valid_o   (valid),
    .stall_cnt_o     (scnt),
    .flush_cnt_o     (fcnt),
    .stall_timeout_o (tmo),
    .protocol_err_o  (perr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string         name;
    logic          pcw, ifw, fl, rv;
    logic [31:0]   rpc, rdata;
    logic          clr;
    logic [31:0]   e_addr, e_instr, e_pc4;
    logic          e_valid;
    logic [CW-1:0] e_sc, e_fc;
    logic          e_to, e_pe;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, logic p, logic w, logic f, logic r,
                              logic [31:0] rp, logic [31:0] rd, logic c,
                              logic [31:0] ea, logic [31:0] ei, logic [31:0] ep,
                              logic ev, int esc, int efc, logic eto, logic epe);
    vec_t v;
    v.name = name; v.pcw = p; v.ifw = w; v.fl = f; v.rv = r;
    v.rpc = rp; v.rdata = rd; v.clr = c;
    v.e_addr = ea; v.e_instr = ei; v.e_pc4 = ep; v.e_valid = ev;
    v.e_sc = CW'(esc); v.e_fc = CW'(efc); v.e_to = eto; v.e_pe = epe;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] ea, logic [31:0] ei, logic [31:0] ep,
                       logic ev, logic [CW-1:0] esc, logic [CW-1:0] efc,
                       logic eto, logic epe);
    n_vec++;
    if (addr !== ea || instr !== ei || pc4 !== ep || valid !== ev ||
        scnt !== esc || fcnt !== efc || tmo !== eto || perr !== epe) begin
      n_miss++;
      $display("FAIL %s: got addr=%h instr=%h pc4=%h v=%b sc=%0d fc=%0d to=%b pe=%b | want addr=%h instr=%h pc4=%h v=%b sc=%0d fc=%0d to=%b pe=%b",
               name, addr, instr, pc4, valid, scnt, fcnt, tmo, perr,
               ea, ei, ep, ev, esc, efc, eto, epe);
    end
  endtask

  task automatic drive(logic p, logic w, logic f, logic r, logic [31:0] rp,
                       logic [31:0] rd, logic c);
    pcw = p; ifw = w; fl = f; rv = r; rpc = rp; rdata = rd; clr = c;
  endtask

  initial begin
    // ---------------- vector table ----------------
    vecs.push_back(mk("fetch0",  1,1,0,0, 0, 32'hA, 0, 32'h104, 32'hA, 32'h104, 1, 0,0,0,0));
    vecs.push_back(mk("fetch1",  1,1,0,0, 0, 32'hB, 0, 32'h108, 32'hB, 32'h108, 1, 0,0,0,0));
    vecs.push_back(mk("fetch2",  1,1,0,0, 0, 32'hC, 0, 32'h10C, 32'hC, 32'h10C, 1, 0,0,0,0));
    vecs.push_back(mk("stall1",  0,0,0,0, 0, 32'hDEAD, 0, 32'h10C, 32'hC, 32'h10C, 1, 1,0,0,0));
    vecs.push_back(mk("stall2",  0,0,0,0, 0, 32'hDEAD, 0, 32'h10C, 32'hC, 32'h10C, 1, 2,0,0,0));
    vecs.push_back(mk("jump",    1,0,1,1, 32'h403, 32'hBAD, 0, 32'h400, 0, 0, 0, 2,1,0,0));
    vecs.push_back(mk("clr_fetch", 1,1,0,0, 0, 32'h11, 1, 32'h404, 32'h11, 32'h404, 1, 0,0,0,0));
    for (int k = 1; k <= 3; k++)
      vecs.push_back(mk($sformatf("jr_hold%0d", k), 0,0,0,1, 32'h800, 32'hBAD, 0,
                        32'h404, 32'h11, 32'h404, 1, k,0,0,0));
    vecs.push_back(mk("jr_go",   1,1,1,1, 32'h800, 32'h22, 0, 32'h800, 0, 0, 0, 3,1,0,0));
    vecs.push_back(mk("fetch3",  1,1,0,0, 0, 32'h33, 0, 32'h804, 32'h33, 32'h804, 1, 3,1,0,0));
    for (int k = 1; k <= 4; k++)
      vecs.push_back(mk($sformatf("wdog%0d", k), 0,0,0,0, 0, 0, 0,
                        32'h804, 32'h33, 32'h804, 1, 3+k,1,(k == 4),0));
    vecs.push_back(mk("wdog_sticky", 1,1,0,0, 0, 32'h44, 0, 32'h808, 32'h44, 32'h808, 1, 7,1,1,0));
    vecs.push_back(mk("clr_over_stall", 0,0,0,0, 0, 0, 1, 32'h808, 32'h44, 32'h808, 1, 0,0,0,0));
    for (int k = 1; k <= 16; k++)
      vecs.push_back(mk($sformatf("stall_sat%0d", k), 0,0,0,0, 0, 0, 0,
                        32'h808, 32'h44, 32'h808, 1, (k > 15) ? 15 : k, 0, (k >= 4), 0));
    vecs.push_back(mk("clr_over_flush", 1,1,1,0, 0, 32'h55, 1, 32'h80C, 0, 0, 0, 0,0,0,0));
    for (int k = 1; k <= 16; k++)
      vecs.push_back(mk($sformatf("flush_sat%0d", k), 0,0,1,0, 0, 0, 0,
                        32'h80C, 0, 0, 0, 0, (k > 15) ? 15 : k, 0, 0));
    vecs.push_back(mk("wrap_redir", 1,1,0,1, 32'hFFFF_FFFE, 32'h66, 0,
                      32'hFFFF_FFFC, 32'h66, 32'h810, 1, 0,15,0,0));
    vecs.push_back(mk("wrap",    1,1,0,0, 0, 32'h77, 0, 32'h0, 32'h77, 32'h0, 1, 0,15,0,0));
    vecs.push_back(mk("dup_err", 0,1,0,0, 0, 32'h88, 0, 32'h0, 32'h88, 32'h4, 1, 0,15,0,1));
    vecs.push_back(mk("err_sticky", 1,1,0,0, 0, 32'h99, 0, 32'h4, 32'h99, 32'h4, 1, 0,15,0,1));
    vecs.push_back(mk("clr_err", 1,1,0,0, 0, 32'hAA, 1, 32'h8, 32'hAA, 32'h8, 1, 0,0,0,0));
    vecs.push_back(mk("flush_dup_err", 0,1,1,0, 0, 32'hBB, 0, 32'h8, 0, 0, 0, 0,1,0,1));

    // ---------------- reset ----------------
    rst_n = 1'b0;
    drive(0,0,0,0,0,0,0);
    repeat (3) @(posedge clk);
    #1;
    check("reset", 32'h100, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // ---------------- table ----------------
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].pcw, vecs[i].ifw, vecs[i].fl, vecs[i].rv,
            vecs[i].rpc, vecs[i].rdata, vecs[i].clr);
      @(posedge clk);
      #1;
      check(vecs[i].name, vecs[i].e_addr, vecs[i].e_instr, vecs[i].e_pc4,
            vecs[i].e_valid, vecs[i].e_sc, vecs[i].e_fc, vecs[i].e_to, vecs[i].e_pe);
    end

    // ---------------- asynchronous reset mid-cycle ----------------
    drive(0,0,0,0,0,0,0);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset", 32'h100, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check("held_in_reset", 32'h100, 0, 0, 0, 0, 0, 0, 0);

    // Release while a stall is being requested: the first edge counts it normally.
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("release_in_stall", 32'h100, 0, 0, 0, 1, 0, 0, 0);
    drive(1,1,0,0,0,32'hCC,0);
    @(posedge clk);
    #1;
    check("after_release", 32'h104, 32'hCC, 32'h104, 1, 1, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
